// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_unit
//  Brief    : Multi-cycle SLL/SRL/SRA controller for the RV32I ALU path,
//             one bit per cycle (two when SEQ_SHIFT_DUAL_STEP_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [1:0]         i_op,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_result
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   work;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op;
    logic               fill;
    logic               ready;
    logic               busy;
    logic               valid;
    logic [WIDTH-1:0]   result;

    logic               step_two;
    logic [WIDTH-1:0]   shifted;
    logic [SHAMT_W-1:0] cnt_next;

    // SRL latches a zero fill, so one right-shift path serves SRL and SRA.
    always_comb begin
        step_two = 1'b0;
`ifdef SEQ_SHIFT_DUAL_STEP_EN
        step_two = |cnt[SHAMT_W-1:1];
`endif
        if (op == OP_SLL) begin
            shifted = step_two ? {work[WIDTH-3:0], 2'b00} : {work[WIDTH-2:0], 1'b0};
        end else begin
            shifted = step_two ? {{2{fill}}, work[WIDTH-1:2]} : {fill, work[WIDTH-1:1]};
        end
        cnt_next = cnt - {{(SHAMT_W-2){1'b0}}, step_two, ~step_two};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            work   <= '0;
            cnt    <= '0;
            op     <= OP_SLL;
            fill   <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        work  <= i_data;
                        cnt   <= (i_op == OP_RSV) ? '0 : i_shamt;
                        op    <= i_op;
                        fill  <= (i_op == OP_SRA) & i_data[WIDTH-1];
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        result <= work;
                        valid  <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        work <= shifted;
                        cnt  <= cnt_next;
                    end
                end
                ST_DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ready  = ready;
    assign o_busy   = busy;
    assign o_valid  = valid;
    assign o_result = result;

endmodule
`default_nettype wire
